// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: datapath width, instruction size and the
// fetch-stage state encoding.
package cpu_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

   typedef enum logic [1:0] {
      StBoot   = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched word with its PC, holds it while
// decode stalls, and drops its valid bit on squash or drain.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
);

   logic            valid_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_q;

   // Clear only touches valid; the payload keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
      end else if (load) begin
         valid_q    <= 1'b1;
         instr_q    <= instr_in;
         pc_q       <= pc_in;
         pc_plus4_q <= pc_in + XLEN'(INSTR_BYTES);
      end else if (clear) begin
         valid_q    <= 1'b0;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc       = pc_q;
   assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory and hands captured words to decode over a valid/ready handshake.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned     IMEM_WORDS = 256,
   parameter logic [XLEN-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            id_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            halt,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic            misalign_err,
   output logic            range_err,
   output logic [XLEN-1:0] fetch_count
);

   // One extra bit so a full 4 GiB memory size does not overflow the bound.
   localparam logic [XLEN:0] ImemBytes = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(INSTR_BYTES);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] count_q, count_d;
   logic            range_q, range_d;
   logic            misalign_q, misalign_d;

   logic            out_of_range;
   logic            accept;
   logic            drain;
   logic            load;
   logic            clear;
   logic [XLEN-1:0] fetch_word;

   assign out_of_range = ({1'b0, pc_q} >= ImemBytes);
   assign fetch_word   = out_of_range ? NOP_INSTR : imem_instr;

   assign accept = (state_q == StRun) && !halt && (!if_valid || id_ready);
   // Decode may still take a live word while fetching is stopped.
   assign drain  = ((state_q == StHalted) || ((state_q == StRun) && halt)) &&
                   if_valid && id_ready;

   // Datapath next-state: redirect beats accept beats hold.
   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      range_d    = range_q;
      misalign_d = 1'b0;
      load       = 1'b0;
      clear      = 1'b0;
      if (redirect_valid) begin
         pc_d       = {redirect_target[XLEN-1:2], 2'b00};
         clear      = 1'b1;
         misalign_d = |redirect_target[1:0];
      end else if (accept) begin
         load    = 1'b1;
         pc_d    = pc_q + XLEN'(INSTR_BYTES);
         count_d = count_q + 1'b1;
         if (out_of_range) begin
            range_d = 1'b1;
         end
      end else if (drain) begin
         clear = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:   state_d = halt ? StHalted : StRun;
         StRun:    if (halt && !redirect_valid) state_d = StHalted;
         StHalted: if (!halt) state_d = StRun;
         default:  state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         count_q    <= '0;
         range_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         count_q    <= count_d;
         range_q    <= range_d;
         misalign_q <= misalign_d;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .clear    (clear),
      .instr_in (fetch_word),
      .pc_in    (pc_q),
      .valid    (if_valid),
      .instr    (if_instr),
      .pc       (if_pc),
      .pc_plus4 (if_pc_plus4)
   );

   assign imem_addr    = pc_q;
   assign misalign_err = misalign_q;
   assign range_err    = range_q;
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard of expected fetches is
// filled as stimulus is planned and drained on each decode handshake.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        misalign_err;
   logic        range_err;
   logic [31:0] fetch_count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;

   instr_fetch #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (256),
      .NOP_INSTR  (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .id_ready        (id_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt            (halt),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .misalign_err    (misalign_err),
      .range_err       (range_err),
      .fetch_count     (fetch_count)
   );

   assign imem_instr = mem[imem_addr[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected word for a fetch address; 1024 bytes of memory.
   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc       = pc;
      e.instr    = (pc < 32'd1024) ? mem[pc[9:2]] : 32'h0000_0000;
      e.pc_plus4 = pc + 32'd4;
      sb.push_back(e);
   endtask

   // Raise id_ready and compare each live word against the scoreboard head.
   // id_ready drops after the last handshake edge.
   task automatic consume(input int n);
      int   got = 0;
      int   cyc = 0;
      exp_t e;
      id_ready = 1'b1;
      while (got < n && cyc < 20) begin
         if (if_valid) begin
            e = sb.pop_front();
            checks++;
            if (if_pc !== e.pc || if_instr !== e.instr || if_pc_plus4 !== e.pc_plus4) begin
               errors++;
               $display("FAIL sb_word: got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                        if_pc, if_instr, if_pc_plus4, e.pc, e.instr, e.pc_plus4);
            end
            got++;
         end
         step();
         cyc++;
      end
      id_ready = 1'b0;
      if (got < n) begin
         checks++;
         errors++;
         $display("FAIL sb_timeout: got %0d words want %0d", got, n);
         sb.delete();
      end
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid  = 1'b1;
      redirect_target = target;
      step();
      redirect_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      checks++;
      if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 ||
          misalign_err !== 1'b0 || range_err !== 1'b0 || fetch_count !== 32'h0 ||
          imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset: got v=%b i=%h pc=%h p4=%h m=%b r=%b cnt=%0d a=%h want all zero",
                  if_valid, if_instr, if_pc, if_pc_plus4, misalign_err, range_err,
                  fetch_count, imem_addr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      id_ready = 1'b1;
      step();
      checks++;
      if (if_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_no_capture: got if_valid=%b want 0", if_valid);
      end
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      step();
      checks++;
      if (if_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_latency: got if_valid=%b want 1", if_valid);
      end
      consume(3);
      // The edge that consumed 0x8 also captured 0xC.
      checks++;
      if (fetch_count !== 32'd4 || if_pc !== 32'hC) begin
         errors++;
         $display("FAIL fetch_count: got cnt=%0d pc=%h want 4 / 0000000c", fetch_count, if_pc);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem[3] ||
             imem_addr !== 32'h10 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL stall_hold: got v=%b pc=%h i=%h a=%h cnt=%0d want 1 c %h 10 4",
                     if_valid, if_pc, if_instr, imem_addr, fetch_count, mem[3]);
         end
      end
      push_exp(32'hC); push_exp(32'h10);
      consume(2);
   endtask

   task automatic test_redirect();
      // Stalled on 0x14 here; the redirect squashes it.
      redirect_to(32'h10);
      checks++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h10 || misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL redirect_squash: got v=%b a=%h m=%b want 0 10 0",
                  if_valid, imem_addr, misalign_err);
      end
      push_exp(32'h10);
      consume(1);
      checks++;
      if (fetch_count !== 32'd8) begin
         errors++;
         $display("FAIL redirect_count: got %0d want 8", fetch_count);
      end
   endtask

   task automatic test_misalign();
      redirect_to(32'h13);
      checks++;
      if (imem_addr !== 32'h10 || misalign_err !== 1'b1 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL misalign_set: got a=%h m=%b v=%b want 10 1 0",
                  imem_addr, misalign_err, if_valid);
      end
      step();
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL misalign_pulse: got %b want 0", misalign_err);
      end
      push_exp(32'h10); push_exp(32'h14);
      consume(2);
   endtask

   task automatic test_halt();
      // Word 0x18 is live; halt with id_ready lets decode take it.
      halt     = 1'b1;
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (if_valid !== 1'b0 || imem_addr !== 32'h1C || if_pc !== 32'h18 ||
             fetch_count !== 32'd11) begin
            errors++;
            $display("FAIL halt_freeze: got v=%b a=%h pc=%h cnt=%0d want 0 1c 18 11",
                     if_valid, imem_addr, if_pc, fetch_count);
         end
         step();
      end
      halt = 1'b0;
      step();
      checks++;
      if (if_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_exit: got v=%b want 0", if_valid);
      end
      push_exp(32'h1C);
      consume(1);
   endtask

   task automatic test_range();
      redirect_to(32'h3FC);
      step();
      checks++;
      if (range_err !== 1'b0) begin
         errors++;
         $display("FAIL range_early: got %b want 0", range_err);
      end
      push_exp(32'h3FC); push_exp(32'h400);
      consume(2);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (range_err !== 1'b1) begin
            errors++;
            $display("FAIL range_sticky: got %b want 1", range_err);
         end
         step();
      end
   endtask

   task automatic test_wrap();
      redirect_to(32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC); push_exp(32'h0);
      consume(2);
   endtask

   task automatic test_reset_mid();
      // Stalled on a live word; async reset must clear without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (if_valid !== 1'b0 || fetch_count !== 32'h0 || range_err !== 1'b0 ||
          imem_addr !== 32'h0 || if_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_async: got v=%b cnt=%0d r=%b a=%h pc=%h want all zero",
                  if_valid, fetch_count, range_err, imem_addr, if_pc);
      end
      step();
      halt  = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic test_boot_halt();
      repeat (3) begin
         step();
         checks++;
         if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL boot_halt: got v=%b a=%h want 0 0", if_valid, imem_addr);
         end
      end
      halt = 1'b0;
      step();
      push_exp(32'h0);
      consume(1);
      checks++;
      if (fetch_count !== 32'd2) begin
         errors++;
         $display("FAIL boot_halt_count: got %0d want 2", fetch_count);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[0] = 32'h0022_1820;
      mem[1] = 32'h8C22_0000;
      mem[2] = 32'hAC23_0000;
      rst_n           = 1'b0;
      id_ready        = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      halt            = 1'b0;
      #1;
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_misalign();
      test_halt();
      test_range();
      test_wrap();
      test_reset_mid();
      test_boot_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage. It is the initiator side of the instruction-memory read interface: it owns the program counter and drives a word-aligned byte address to the combinational instruction memory. It captures the returned word into an IF/ID pipeline register and offers it to decode with a valid/ready handshake. Branch redirects from later stages squash the fetched word; a halt input freezes fetching.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 256, instruction memory depth in 32-bit words; addresses at or above IMEM_WORDS*4 are out of range
NOP_INSTR, 32'h0000_0000, word substituted for out-of-range fetches

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory; always equals the PC register, bits[1:0] always 0
imem_instr  input  32  instruction word returned combinationally for imem_addr
id_ready  input  1  decode accepts if_instr this cycle
redirect_valid  input  1  branch/jump taken; single-cycle pulse
redirect_target  input  32  new PC for the redirect
halt  input  1  level; stop issuing new fetches while high
if_valid  output  1  if_instr/if_pc/if_pc_plus4 hold a live instruction
if_instr  output  32  fetched instruction
if_pc  output  32  address of if_instr
if_pc_plus4  output  32  if_pc + 4, mod 2^32
misalign_err  output  1  one-cycle pulse: redirect_target[1:0] was nonzero
range_err  output  1  sticky: an out-of-range address was fetched
fetch_count  output  32  number of instructions captured into IF/ID, wraps

Behaviour:
- Reset (async assert, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - if_valid=0; if_instr=NOP_INSTR; if_pc=0; if_pc_plus4=0.
  - misalign_err=0; range_err=0; fetch_count=0.
- imem_addr = pc, combinational from the register. The memory indexes imem_addr[9:2].
- FSM states:
  - BOOT: first cycle after reset release. No capture. Goes to RUN, or to HALTED if halt=1.
  - RUN: normal fetching. Goes to HALTED when halt=1 and no redirect in the same cycle.
  - HALTED: no captures. Goes to RUN when halt=0.
- accept = (state==RUN) && !halt && (!if_valid || id_ready).
- Priority per cycle: redirect > accept > hold.
- Redirect (any state, including BOOT and HALTED):
  - pc <= {redirect_target[31:2],2'b00}.
  - if_valid <= 0, which squashes any word decode did not take this cycle. A word taken this cycle (id_ready=1) counts as consumed.
  - No capture, no fetch_count increment.
  - misalign_err=1 for exactly that next cycle if redirect_target[1:0]!=0.
  - The state does not change because of the redirect.
- Accept, no redirect:
  - if_instr <= imem_instr, or NOP_INSTR if pc >= IMEM_WORDS*4 (range_err <= 1, sticky until reset).
  - if_pc <= pc; if_pc_plus4 <= pc+4; if_valid <= 1.
  - pc <= pc+4 (0xFFFF_FFFC wraps to 0).
  - fetch_count <= fetch_count+1 (wraps).
- Stall (if_valid=1, id_ready=0, no redirect): all IF/ID outputs and pc hold exactly.
- Halt drain: in HALTED, or in RUN with halt=1, if if_valid=1 and id_ready=1, then if_valid <= 0 and the other outputs hold.
- Throughput: one instruction per cycle while id_ready=1. First valid word appears 2 cycles after rst_n deassert (BOOT, then capture).
- Reset asserted mid-stall or mid-redirect immediately returns all state to reset values.

Decomposition:
- Shared package cpu_pkg: XLEN=32, INSTR_BYTES=4, NOP_INSTR, RESET_PC default, fetch FSM state enum (BOOT, RUN, HALTED).
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load, hold and squash controls. PC/FSM logic stays in instr_fetch.

Test Plan:
- Reset release, id_ready=1, memory words 0x00221820, 0x8C220000, 0xAC230000 -> cycle 2 if_pc=0/if_instr=0x00221820; then 4/0x8C220000, 8/0xAC230000; fetch_count=3 after three captures.
- id_ready low for 3 cycles while if_pc=4 -> if_valid, if_instr, if_pc and imem_addr=8 held; count frozen; resumes with if_pc=8 after id_ready=1.
- Redirect to 0x10 while stalled on if_pc=8 -> next cycle if_valid=0, imem_addr=0x10; following cycle if_pc=0x10, if_pc_plus4=0x14.
- Redirect to 0x13 -> imem_addr=0x10, misalign_err high exactly 1 cycle.
- halt=1 with valid word and id_ready=1 -> if_valid drops after handshake, pc frozen; halt=0 -> fetching resumes at held pc.
- Redirect to 0x3FC, run 2 captures -> second capture pc=0x400 gives if_instr=NOP_INSTR, range_err=1 and stays 1.
